// File: rtl/iact_feeder.sv
// Input-activation feeder: captures a streamed feature map into RAM, then replays
// it as convolution windows on M lanes with the systolic array's loop-control framing.
module iact_feeder #(
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int STREAM_WIDTH = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid_write,
  input  logic                               start,
  input  logic [DATA_WIDTH*STREAM_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0]              data_out [0:M-1],
  output logic [ADDR_WIDTH-1:0]              counter,
  output logic [1:0]                         state,
  output logic                               wr_check,
  output logic [7:0]                         last,
  output logic                               ram_full,
  output logic [ADDR_WIDTH-1:0]              rd_idx,
  input  logic [1:0]                         stride,
  input  logic [ADDR_WIDTH-1:0]              chans_per_mem,
  input  logic [ADDR_WIDTH-1:0]              In_cols,
  output logic                               last_out,
  input  logic [ADDR_WIDTH-1:0]              k_dimension,
  input  logic [ADDR_WIDTH-1:0]              o_dimension,
  output logic [8:0]                         loop_ctrl
);

  localparam int MEM_AW = $clog2(DEPTH);
  // Array width does not change the lane count; it only has to be non-zero.
  localparam int LANES  = (N > 0) ? M : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WRITE = 2'b01,
    S_READ  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t state_q, state_nxt;

  logic [DATA_WIDTH*STREAM_WIDTH-1:0] mem [0:DEPTH-1];

  logic [1:0]            stride_r;
  logic [ADDR_WIDTH-1:0] cpm_r, in_r, k_r, o_r, total_r;

  logic [ADDR_WIDTH-1:0] oy_p0, ox_p0, ky_p0, kx_p0, c_p0;
  logic                  rd_done;
  logic                  vld_p1, first_p1, lastel_p1, final_p1;

  logic                  wr_full, wr_accept, rd_degen, rd_issue;
  logic                  c_last, kx_last, ky_last, ox_last, oy_last;
  logic                  first_p0, lastel_p0, final_p0;
  logic [ADDR_WIDTH-1:0] s_eff, iy, ix, addr_p0;

  assign state     = state_q;
  assign wr_full   = (counter == total_r);
  assign wr_accept = (state_q == S_WRITE) && valid_write && !ram_full && !wr_full;
  assign rd_degen  = (o_r == '0) || (k_r == '0) || (cpm_r == '0);
  assign rd_issue  = (state_q == S_READ) && !rd_done && !rd_degen;

  assign c_last    = (c_p0  == cpm_r - 1'b1);
  assign kx_last   = (kx_p0 == k_r - 1'b1);
  assign ky_last   = (ky_p0 == k_r - 1'b1);
  assign ox_last   = (ox_p0 == o_r - 1'b1);
  assign oy_last   = (oy_p0 == o_r - 1'b1);
  assign first_p0  = (ky_p0 == '0) && (kx_p0 == '0) && (c_p0 == '0);
  assign lastel_p0 = ky_last && kx_last && c_last;
  assign final_p0  = lastel_p0 && ox_last && oy_last;

  always_comb begin
    s_eff   = (stride_r == 2'd0) ? ADDR_WIDTH'(1) : ADDR_WIDTH'(stride_r);
    iy      = oy_p0 * s_eff + ky_p0;
    ix      = ox_p0 * s_eff + kx_p0;
    addr_p0 = (iy * in_r + ix) * cpm_r + c_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // READ only ends once the last issued element has left the output stage.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (start)              state_nxt = S_WRITE;
      S_WRITE: if (wr_full)            state_nxt = S_READ;
      S_READ:  if (rd_done && !vld_p1) state_nxt = S_DONE;
      S_DONE:  if (!start)             state_nxt = S_IDLE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[counter[MEM_AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter   <= '0;
      rd_idx    <= '0;
      last      <= '0;
      ram_full  <= 1'b0;
      wr_check  <= 1'b0;
      last_out  <= 1'b0;
      loop_ctrl <= '0;
      for (int u = 0; u < LANES; u++) data_out[u] <= '0;
      stride_r  <= '0;
      cpm_r     <= '0;
      in_r      <= '0;
      k_r       <= '0;
      o_r       <= '0;
      total_r   <= '0;
      oy_p0     <= '0;
      ox_p0     <= '0;
      ky_p0     <= '0;
      kx_p0     <= '0;
      c_p0      <= '0;
      rd_done   <= 1'b0;
      vld_p1    <= 1'b0;
      first_p1  <= 1'b0;
      lastel_p1 <= 1'b0;
      final_p1  <= 1'b0;
    end else begin
      wr_check  <= wr_accept;

      // ---- issue stage (p0 indices -> p1 address/flags) ----
      vld_p1    <= rd_issue;
      first_p1  <= rd_issue && first_p0;
      lastel_p1 <= rd_issue && lastel_p0;
      final_p1  <= rd_issue && final_p0;

      // ---- output stage (p1 -> lanes/control, aligned with RAM read) ----
      loop_ctrl <= {6'b0, lastel_p1, first_p1, vld_p1};
      last_out  <= final_p1;
      if (vld_p1) begin
        for (int u = 0; u < LANES; u++)
          data_out[u] <= mem[rd_idx[MEM_AW-1:0]][u*DATA_WIDTH +: DATA_WIDTH];
      end

      if (state_q == S_IDLE && start) begin
        stride_r <= stride;
        cpm_r    <= chans_per_mem;
        in_r     <= In_cols;
        k_r      <= k_dimension;
        o_r      <= o_dimension;
        total_r  <= In_cols * In_cols * chans_per_mem;
        counter  <= '0;
        last     <= '0;
        oy_p0    <= '0;
        ox_p0    <= '0;
        ky_p0    <= '0;
        kx_p0    <= '0;
        c_p0     <= '0;
        rd_done  <= 1'b0;
      end

      if (wr_accept) counter <= counter + 1'b1;

      if (state_q == S_WRITE && wr_full) begin
        ram_full <= 1'b1;
        counter  <= '0;
      end

      if (state_q == S_READ && !rd_done) begin
        if (rd_degen) begin
          rd_done <= 1'b1;
        end else begin
          rd_idx  <= addr_p0;
          counter <= counter + 1'b1;
          last    <= 8'(oy_p0 * o_r + ox_p0);
          if (final_p0) rd_done <= 1'b1;
          // Odometer advance: c fastest, oy slowest.
          if (c_last) begin
            c_p0 <= '0;
            if (kx_last) begin
              kx_p0 <= '0;
              if (ky_last) begin
                ky_p0 <= '0;
                if (ox_last) begin
                  ox_p0 <= '0;
                  oy_p0 <= oy_p0 + 1'b1;
                end else begin
                  ox_p0 <= ox_p0 + 1'b1;
                end
              end else begin
                ky_p0 <= ky_p0 + 1'b1;
              end
            end else begin
              kx_p0 <= kx_p0 + 1'b1;
            end
          end else begin
            c_p0 <= c_p0 + 1'b1;
          end
        end
      end

      if (state_q == S_DONE && !start) ram_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iact_feeder.sv
// Bench for iact_feeder: table of job configurations, each written then replayed,
// with a scoreboard of expected window elements built from the address formula.
module tb_iact_feeder;

  localparam int M  = 4;
  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_write = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   data_in = '0;
  logic [DW-1:0] data_out [0:M-1];
  logic [AW-1:0] counter;
  logic [1:0]    state;
  logic          wr_check;
  logic [7:0]    last;
  logic          ram_full;
  logic [AW-1:0] rd_idx;
  logic [1:0]    stride = '0;
  logic [AW-1:0] chans_per_mem = '0;
  logic [AW-1:0] In_cols = '0;
  logic          last_out;
  logic [AW-1:0] k_dimension = '0;
  logic [AW-1:0] o_dimension = '0;
  logic [8:0]    loop_ctrl;

  iact_feeder #(.M(M), .N(4), .DATA_WIDTH(DW), .STREAM_WIDTH(4), .ADDR_WIDTH(AW), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .valid_write(valid_write), .start(start), .data_in(data_in),
    .data_out(data_out), .counter(counter), .state(state), .wr_check(wr_check), .last(last),
    .ram_full(ram_full), .rd_idx(rd_idx), .stride(stride), .chans_per_mem(chans_per_mem),
    .In_cols(In_cols), .last_out(last_out), .k_dimension(k_dimension),
    .o_dimension(o_dimension), .loop_ctrl(loop_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    int in_cols; int cpm; int k; int o; int s; bit gaps; bit extra;
    int reads; int windows; int lastpix;
  } cfg_t;

  typedef struct {
    int addr; logic [31:0] data; logic [8:0] ctrl; logic fin;
  } exp_t;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  logic [31:0] tb_mem [0:1023];
  int n_elem, n_first, n_lastel, n_lastout, n_wr;
  logic [AW-1:0] prev_rd = '0;
  logic [31:0] final_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dout_word();
    return {data_out[3], data_out[2], data_out[1], data_out[0]};
  endfunction

  function automatic logic [31:0] mk_word(input int a, input int job);
    logic [31:0] w;
    if (job == 0) begin
      w = {4{8'(a)}};
    end else begin
      for (int u = 0; u < 4; u++) w[u*8 +: 8] = 8'(a * 5 + u * 64 + job * 7);
    end
    return w;
  endfunction

  // Monitor: pops one expected element per valid output cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (loop_ctrl[0]) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_idx", 64'(prev_rd), 64'(e.addr));
          chk("data_out", 64'(dout_word()), 64'(e.data));
          chk("loop_ctrl", 64'(loop_ctrl), 64'(e.ctrl));
          chk("last_out", 64'(last_out), 64'(e.fin));
          n_elem++;
        end
      end
      if (loop_ctrl[1]) n_first++;
      if (loop_ctrl[2]) n_lastel++;
      if (last_out) n_lastout++;
      if (wr_check) n_wr++;
      prev_rd = rd_idx;
    end
  end

  task automatic gen_expected(input cfg_t c);
    int s, addr;
    s = (c.s == 0) ? 1 : c.s;
    for (int oy = 0; oy < c.o; oy++)
      for (int ox = 0; ox < c.o; ox++)
        for (int ky = 0; ky < c.k; ky++)
          for (int kx = 0; kx < c.k; kx++)
            for (int ch = 0; ch < c.cpm; ch++) begin
              exp_t e;
              logic fst, lst;
              addr = ((oy * s + ky) * c.in_cols + (ox * s + kx)) * c.cpm + ch;
              fst = (ky == 0 && kx == 0 && ch == 0);
              lst = (ky == c.k - 1 && kx == c.k - 1 && ch == c.cpm - 1);
              e.addr = addr;
              e.data = tb_mem[addr];
              e.ctrl = {6'b0, lst, fst, 1'b1};
              e.fin  = lst && (ox == c.o - 1) && (oy == c.o - 1);
              if (e.fin) final_word = e.data;
              sb.push_back(e);
            end
  endtask

  task automatic run_job(input cfg_t c, input int job);
    int total;
    total = c.in_cols * c.in_cols * c.cpm;
    n_elem = 0; n_first = 0; n_lastel = 0; n_lastout = 0; n_wr = 0;
    In_cols = AW'(c.in_cols); chans_per_mem = AW'(c.cpm);
    k_dimension = AW'(c.k); o_dimension = AW'(c.o); stride = 2'(c.s);
    start = 1'b1;
    @(negedge clk);
    chk("enter_write", 64'(state), 64'd1);
    chk("write_cnt0", 64'(counter), 64'd0);
    for (int a = 0; a < total; a++) begin
      if (c.gaps) begin
        valid_write = 1'b0;
        @(negedge clk);
      end
      tb_mem[a] = mk_word(a, job);
      data_in = tb_mem[a];
      valid_write = 1'b1;
      @(negedge clk);
    end
    gen_expected(c);
    valid_write = c.extra;
    data_in = 32'hDEADBEEF;
    chk("count_total", 64'(counter), 64'(total));
    chk("full_pending", 64'(ram_full), 64'd0);
    @(negedge clk);
    valid_write = 1'b0;
    chk("ram_full_set", 64'(ram_full), 64'd1);
    chk("enter_read", 64'(state), 64'd2);
    chk("read_cnt0", 64'(counter), 64'd0);
    for (int i = 0; i < 400 && state != 2'b11; i++) @(negedge clk);
    chk("reach_done", 64'(state), 64'd3);
    chk("wr_accepts", 64'(n_wr), 64'(total));
    chk("n_elem", 64'(n_elem), 64'(c.reads));
    chk("n_first", 64'(n_first), 64'(c.windows));
    chk("n_lastel", 64'(n_lastel), 64'(c.windows));
    chk("n_lastout", 64'(n_lastout), (c.reads > 0) ? 64'd1 : 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("read_count", 64'(counter), 64'(c.reads));
    chk("last_pix", 64'(last), 64'(c.lastpix));
    @(negedge clk);
    chk("done_ctrl", 64'(loop_ctrl), 64'd0);
    chk("done_lastout", 64'(last_out), 64'd0);
    chk("done_full", 64'(ram_full), 64'd1);
    if (c.reads > 0) chk("done_hold", 64'(dout_word()), 64'(final_word));
    start = 1'b0;
    @(negedge clk);
    chk("back_idle", 64'(state), 64'd0);
    chk("full_clear", 64'(ram_full), 64'd0);
    sb.delete();
  endtask

  cfg_t jobs [4];

  initial begin
    jobs[0] = '{in_cols:4, cpm:1, k:2, o:2, s:2, gaps:0, extra:1, reads:16, windows:4, lastpix:3};
    jobs[1] = '{in_cols:3, cpm:2, k:2, o:2, s:1, gaps:0, extra:0, reads:32, windows:4, lastpix:3};
    jobs[2] = '{in_cols:4, cpm:1, k:3, o:2, s:0, gaps:1, extra:1, reads:36, windows:4, lastpix:3};
    jobs[3] = '{in_cols:2, cpm:1, k:2, o:0, s:1, gaps:0, extra:0, reads:0,  windows:0, lastpix:0};

    repeat (3) @(negedge clk);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_counter", 64'(counter), 64'd0);
    chk("rst_rd_idx", 64'(rd_idx), 64'd0);
    chk("rst_ctrl", 64'(loop_ctrl), 64'd0);
    chk("rst_dout", 64'(dout_word()), 64'd0);
    chk("rst_flags", 64'({ram_full, wr_check, last_out}), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Abort a job after five written words.
    In_cols = 16'd4; chans_per_mem = 16'd1; k_dimension = 16'd2; o_dimension = 16'd2; stride = 2'd2;
    start = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 5; a++) begin
      data_in = 32'hA5A5A500 | 32'(a);
      valid_write = 1'b1;
      @(negedge clk);
    end
    chk("mid_count", 64'(counter), 64'd5);
    chk("mid_wrchk", 64'(wr_check), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_state", 64'(state), 64'd0);
    chk("abort_count", 64'(counter), 64'd0);
    chk("abort_wrchk", 64'(wr_check), 64'd0);
    valid_write = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int j = 0; j < 4; j++) run_job(jobs[j], j);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iact_feeder.md
Name: iact_feeder

Overview:
Input-activation feeder for the M x N weight-stationary systolic array.
- Write phase: captures a streamed input feature map (In_cols x In_cols pixels, chans_per_mem words per pixel) into an internal single-port-per-side RAM.
- Read phase: replays the map as convolution windows (k_dimension x k_dimension, given stride) on M parallel activation lanes.
- Also drives the array's 9-bit loop-control word.

Parameters:
- M, 4, number of array rows = number of output activation lanes.
- N, 4, number of array columns (kept for interface symmetry; no internal use).
- DATA_WIDTH, 8, bits per activation (B_WIDTH).
- STREAM_WIDTH, 4, activations per write word; must equal M.
- ADDR_WIDTH, 16, RAM address and counter width.
- DEPTH, 1024, RAM words.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- valid_write  in  1  data_in valid this cycle.
- start  in  1  enables operation; level, held high for the whole job.
- data_in  in  DATA_WIDTH*STREAM_WIDTH  write word; lane u = bits [(u+1)*DATA_WIDTH-1 : u*DATA_WIDTH].
- data_out  out  M x DATA_WIDTH (unpacked [0:M-1])  activation lanes to the array.
- counter  out  ADDR_WIDTH  words written (WRITE state) or window reads issued (READ state).
- state  out  2  00 IDLE, 01 WRITE, 10 READ, 11 DONE.
- wr_check  out  1  high in a cycle in which a word is accepted into RAM.
- last  out  8  low 8 bits of the current output-pixel index (oy*o_dimension+ox).
- ram_full  out  1  all words written; held until the state returns to IDLE.
- rd_idx  out  ADDR_WIDTH  current RAM read address.
- stride  in  2  convolution stride; value 0 is treated as 1.
- chans_per_mem  in  ADDR_WIDTH  words per pixel.
- In_cols  in  ADDR_WIDTH  square input width.
- last_out  out  1  one-cycle pulse with the final window element.
- k_dimension  in  ADDR_WIDTH  square kernel width.
- o_dimension  in  ADDR_WIDTH  square output width.
- loop_ctrl  out  9  array control word.
  - bit0 = data_out valid.
  - bit1 = first element of a window (clear psum).
  - bit2 = last element of a window (psum complete).
  - bits 8:3 = 0.

Behaviour:
- Reset (async): state=IDLE; counter, rd_idx, last, loop_ctrl, data_out lanes all 0; ram_full, wr_check, last_out 0. Internal loop indices (oy, ox, ky, kx, c) are 0. RAM contents are don't-care.
- IDLE -> WRITE when start=1. Configuration inputs are sampled on this transition and must be held stable afterwards.
- WRITE:
  - Each cycle with valid_write=1, and ram_full=0: RAM[counter] <= data_in, wr_check=1, counter++.
  - When counter reaches TOTAL = In_cols*In_cols*chans_per_mem, ram_full goes high the next cycle and the state moves to READ. Further valid_write is ignored.
  - TOTAL > DEPTH is unsupported; the address wraps modulo DEPTH.
- READ:
  - On entry, counter resets to 0.
  - Nested loops, outer to inner: oy, ox in [0, o_dimension); ky, kx in [0, k_dimension); c in [0, chans_per_mem).
  - Read address: rd_idx = ((oy*s+ky)*In_cols + (ox*s+kx))*chans_per_mem + c, where s = max(stride, 1).
  - One address is issued per cycle; counter++ per issue.
- Read latency is 1 cycle:
  - data_out[u] = lane u of RAM[rd_idx of the previous cycle].
  - loop_ctrl and last_out are delayed by the same one cycle, so they align with data_out.
  - loop_ctrl[1] is set when ky=kx=c=0 for that element.
  - loop_ctrl[2] is set when ky=kx=k_dimension-1 and c=chans_per_mem-1 for that element.
- After the final address (all loops at maximum):
  - The next cycle outputs the final element with last_out=1 and loop_ctrl[2]=1.
  - The state then becomes DONE.
- DONE:
  - loop_ctrl=0 and last_out=0; data_out holds its last value.
  - DONE -> IDLE when start=0; ram_full clears on entry to IDLE.
- Any state: asserting rst aborts the job immediately and returns to reset values.
- Arithmetic: all address math is unsigned ADDR_WIDTH with truncation.
- Degenerate configuration: o_dimension=0 or k_dimension=0 goes READ -> DONE with no valid outputs and no last_out pulse.

Test Plan:
- Reset mid-WRITE (after 5 words): state=00, counter=0, wr_check=0 on the next edge; a fresh start rewrites from address 0.
- Write ordering, with In_cols=4, chans_per_mem=1, 16 words 0x00..0x0F replicated across lanes: wr_check high for 16 cycles; ram_full=1 after the 16th; a 17th valid_write is not stored.
- Windows, with In_cols=4, k=2, stride=2, o=2, chans_per_mem=1:
  - rd_idx sequence = 0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15.
  - data_out follows one cycle later.
  - last_out pulses once, with the value from address 15.
- loop_ctrl framing on the same configuration: bit0 high for exactly 16 cycles; bit1 high on elements 0,4,8,12; bit2 high on elements 3,7,11,15.
- Stride 1 with chans_per_mem=2, In_cols=3, k=2, o=2: first window addresses 0,1,2,3,6,7,8,9; 32 reads in total.
- valid_write gaps (high every other cycle): counter still reaches 16 and ram_full asserts, with no lost or duplicated words.
